// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - opcode values (OP_ADD .. OP_MUL); 0 and 11..15 are invalid
//   - FSM state encoding for alu_pipe
//   - bit offsets of the flags in the registered result vector, which is
//     laid out as {invalid_op, parity, zero, borrow, c_out, y}; the offsets
//     below are counted from bit B_W (just above y).
package alu_pkg;

    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_ROL       = 4'd8;
    localparam logic [3:0] OP_ROR       = 4'd9;
    localparam logic [3:0] OP_MUL       = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int FLAG_C_OUT   = 0;
    localparam int FLAG_BORROW  = 1;
    localparam int FLAG_ZERO    = 2;
    localparam int FLAG_PARITY  = 3;
    localparam int FLAG_INVALID = 4;
    localparam int NUM_FLAGS    = 5;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add unsigned multiplier.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load a/b, clear the accumulator and begin B_W iterations
//   a, b      : multiplicand and multiplier (sampled on start)
//   done      : high during the cycle whose edge performs the last iteration
//   product   : accumulator value after the current iteration; valid with done
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int B_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [B_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               done,
    output logic [2*B_W-1:0]   product
);

    localparam int CNT_W = $clog2(B_W) + 1;

    logic [2*B_W-1:0] mcand;
    logic [B_W-1:0]   mplier;
    logic [2*B_W-1:0] acc;
    logic [2*B_W-1:0] acc_next;
    logic [CNT_W-1:0] count;
    logic             busy;

    // The multiplicand is shifted left and the multiplier right each
    // iteration, so bit i of b lines up with a<<i at iteration i.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // done is combinational so the parent can capture the final sum on the
    // same edge that would have written it into the accumulator.
    assign done    = busy && (count == CNT_W'(B_W - 1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{B_W{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked ALU with a multi-cycle multiply.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake; opcode, a, b, c_in sampled on accept
//   out_valid/out_ready : output handshake; result held until consumed
//   y                   : result
//   c_out, borrow, zero, parity, invalid_op : result flags
// Non-MUL ops complete on the accept edge; MUL takes B_W further edges.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int B_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     opcode,
    input  logic [B_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic           c_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [B_W-1:0] y,
    output logic           c_out,
    output logic           borrow,
    output logic           zero,
    output logic           parity,
    output logic           invalid_op
);

    localparam int FV_W = B_W + NUM_FLAGS;

    state_t            state;
    logic [FV_W-1:0]   result_q;
    logic              accept;
    logic              is_mul;
    logic              mul_done;
    logic [2*B_W-1:0]  mul_product;
    logic [B_W-1:0]    alu_y;
    logic              alu_c;
    logic              alu_bw;
    logic              alu_inv;
    logic [B_W:0]      wide;
    logic [FV_W-1:0]   alu_vec;
    logic [FV_W-1:0]   mul_vec;

    // zero and parity are always derived from y, so they are formed here
    // once for both the single-cycle and the multiply paths.
    function automatic logic [FV_W-1:0] pack_result(
        input logic [B_W-1:0] ry,
        input logic           rc,
        input logic           rbw,
        input logic           rinv
    );
        logic [FV_W-1:0] v;
        v = '0;
        v[B_W-1:0]              = ry;
        v[B_W + FLAG_C_OUT]     = rc;
        v[B_W + FLAG_BORROW]    = rbw;
        v[B_W + FLAG_ZERO]      = (ry == '0);
        v[B_W + FLAG_PARITY]    = ^ry;
        v[B_W + FLAG_INVALID]   = rinv;
        return v;
    endfunction

    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (opcode == OP_MUL);

    alu_mul_seq #(.B_W(B_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath. OP_MUL falls through with all-zero outputs;
    // its result comes from the sequential multiplier instead.
    always_comb begin
        wide    = '0;
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_bw  = 1'b0;
        alu_inv = 1'b0;
        case (opcode)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                {alu_c, alu_y} = wide;
            end
            OP_ADD_CARRY: begin
                wide = {1'b0, a} + {1'b0, b} + (B_W+1)'(c_in);
                {alu_c, alu_y} = wide;
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                {alu_bw, alu_y} = wide;
            end
            OP_INC: begin
                wide = {1'b0, a} + (B_W+1)'(1);
                {alu_c, alu_y} = wide;
            end
            OP_DEC: begin
                wide = {1'b0, a} - (B_W+1)'(1);
                {alu_bw, alu_y} = wide;
            end
            OP_AND: alu_y = a & b;
            OP_NOT: alu_y = ~a;
            OP_ROL: alu_y = {a[B_W-2:0], a[B_W-1]};
            OP_ROR: alu_y = {a[0], a[B_W-1:1]};
            OP_MUL: alu_y = '0;
            default: alu_inv = 1'b1;
        endcase
    end

    assign alu_vec = pack_result(alu_y, alu_c, alu_bw, alu_inv);
    assign mul_vec = pack_result(mul_product[B_W-1:0],
                                 |mul_product[2*B_W-1:B_W], 1'b0, 1'b0);

    // Control FSM and output register. In HOLD a pop and a push on the same
    // edge overwrite the result directly so out_valid never drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result_q  <= pack_result('0, 1'b0, 1'b0, 1'b0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= ST_MUL;
                        end else begin
                            result_q  <= alu_vec;
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result_q  <= mul_vec;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        if (accept && !is_mul) begin
                            result_q <= alu_vec;
                        end else if (accept) begin
                            out_valid <= 1'b0;
                            state     <= ST_MUL;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign y          = result_q[B_W-1:0];
    assign c_out      = result_q[B_W + FLAG_C_OUT];
    assign borrow     = result_q[B_W + FLAG_BORROW];
    assign zero       = result_q[B_W + FLAG_ZERO];
    assign parity     = result_q[B_W + FLAG_PARITY];
    assign invalid_op = result_q[B_W + FLAG_INVALID];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe with B_W=8.
// Results are compared as a 13-bit vector {invalid_op,parity,zero,borrow,c_out,y}
// against a plain-arithmetic reference model.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       c_out;
    logic       borrow;
    logic       zero;
    logic       parity;
    logic       invalid_op;

    typedef logic [12:0] fv_t;
    fv_t obs;

    int checks = 0;
    int errors = 0;

    localparam fv_t RESET_VEC = 13'b0_0_1_0_0_00000000;

    alu_pipe #(.B_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .a          (a),
        .b          (b),
        .c_in       (c_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .c_out      (c_out),
        .borrow     (borrow),
        .zero       (zero),
        .parity     (parity),
        .invalid_op (invalid_op)
    );

    always #5 clk = ~clk;

    assign obs = {invalid_op, parity, zero, borrow, c_out, y};

    // Reference model: integer arithmetic straight from the opcode table.
    function automatic fv_t ref_model(input int op, input int av, input int bv, input int cin);
        int         r;
        logic [7:0] ry;
        logic       rc;
        logic       rbw;
        logic       rinv;
        r    = 0;
        ry   = 8'd0;
        rc   = 1'b0;
        rbw  = 1'b0;
        rinv = 1'b0;
        case (op)
            1:  begin r = av + bv;       ry = 8'(r % 256); rc = (r > 255); end
            2:  begin r = av + bv + cin; ry = 8'(r % 256); rc = (r > 255); end
            3:  begin r = av - bv;       ry = 8'((r + 256) % 256); rbw = (r < 0); end
            4:  begin r = av + 1;        ry = 8'(r % 256); rc = (r > 255); end
            5:  begin r = av - 1;        ry = 8'((r + 256) % 256); rbw = (r < 0); end
            6:  ry = 8'(av & bv);
            7:  ry = 8'(255 - av);
            8:  ry = 8'((av * 2) % 256 + av / 128);
            9:  ry = 8'(av / 2 + (av % 2) * 128);
            10: begin r = av * bv;       ry = 8'(r % 256); rc = (r >= 256); end
            default: rinv = 1'b1;
        endcase
        return {rinv, ^ry, (ry == 8'd0), rbw, rc, ry};
    endfunction

    task automatic drive_op(input int op, input int av, input int bv, input int cin);
        opcode   = op[3:0];
        a        = av[7:0];
        b        = bv[7:0];
        c_in     = cin[0];
        in_valid = 1'b1;
    endtask

    // Drop in_valid and garble the operands so late changes would be visible.
    task automatic scramble();
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
        c_in     = 1'($urandom);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        scramble();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_result: got %h expected %h", obs, RESET_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int  t_op[11];
        int  t_a[11];
        int  t_b[11];
        int  t_c[11];
        fv_t t_exp[11];
        t_op  = '{1, 3, 5, 12, 0, 2, 4, 6, 7, 8, 9};
        t_a   = '{200, 5, 0, 85, 85, 255, 127, 240, 15, 128, 1};
        t_b   = '{100, 6, 0, 85, 85, 0, 0, 60, 0, 0, 0};
        t_c   = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        t_exp = '{{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd44},
                  {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255},
                  {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255},
                  {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
                  {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0},
                  {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0},
                  {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80},
                  {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30},
                  {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0},
                  {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01},
                  {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80}};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_op(t_op[i], t_a[i], t_b[i], t_c[i]);
            @(posedge clk);
            #1;
            scramble();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL directed_valid[%0d]: got %b expected 1", i, out_valid);
            end
            checks++;
            if (obs !== t_exp[i]) begin
                errors++;
                $display("[TB] FAIL directed_result[%0d] op %0d: got %h expected %h", i, t_op[i], obs, t_exp[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_pop[%0d]: got %b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_mul();
        int  m_a[2];
        int  m_b[2];
        fv_t m_exp[2];
        int  lat;
        m_a   = '{15, 16};
        m_b   = '{17, 16};
        m_exp = '{{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255},
                  {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0}};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive_op(10, m_a[i], m_b[i], 0);
            @(posedge clk);
            #1;
            scramble();
            lat = 0;
            while (lat < 20 && out_valid !== 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL mul_busy_in_ready[%0d] lat %0d: got %b expected 0", i, lat, in_ready);
                end
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("[TB] FAIL mul_latency[%0d]: got %0d expected 8", i, lat);
            end
            checks++;
            if (obs !== m_exp[i]) begin
                errors++;
                $display("[TB] FAIL mul_result[%0d]: got %h expected %h", i, obs, m_exp[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_pressure();
        fv_t exp_add;
        fv_t exp_inc;
        exp_add = ref_model(1, 10, 20, 0);
        exp_inc = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0};
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(1, 10, 20, 0);
        @(posedge clk);
        #1;
        drive_op(4, 255, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_handshake[%0d]: got valid %b ready %b expected 1 0", k, out_valid, in_ready);
            end
            checks++;
            if (obs !== exp_add) begin
                errors++;
                $display("[TB] FAIL bp_stable[%0d]: got %h expected %h", k, obs, exp_add);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        scramble();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_valid_kept: got %b expected 1", out_valid);
        end
        checks++;
        if (obs !== exp_inc) begin
            errors++;
            $display("[TB] FAIL bp_queued_inc: got %h expected %h", obs, exp_inc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int  op;
        int  av;
        int  bv;
        int  cv;
        fv_t e;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            op = int'($urandom_range(9, 1));
            av = int'($urandom_range(255, 0));
            bv = int'($urandom_range(255, 0));
            cv = int'($urandom_range(1, 0));
            drive_op(op, av, bv, cv);
            e = ref_model(op, av, bv, cv);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", k, in_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || obs !== e) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d] op %0d: got valid %b %h expected 1 %h", k, op, out_valid, obs, e);
            end
        end
        scramble();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        bit  seen;
        fv_t e;
        e = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
        out_ready = 1'b1;
        @(negedge clk);
        drive_op(10, 15, 17, 0);
        @(posedge clk);
        #1;
        scramble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL midmul_reset_values: got valid %b %h expected 0 %h", out_valid, obs, RESET_VEC);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midmul_discard: got out_valid seen %b expected 0", seen);
        end
        @(negedge clk);
        drive_op(1, 1, 1, 0);
        @(posedge clk);
        #1;
        scramble();
        checks++;
        if (out_valid !== 1'b1 || obs !== e) begin
            errors++;
            $display("[TB] FAIL midmul_next_add: got valid %b %h expected 1 %h", out_valid, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    // Randomised traffic: the model tracks whether a result is held and how
    // many edges remain on an in-flight multiply.
    task automatic test_random();
        int  mul_left;
        bit  hold;
        bit  model_ready;
        bit  pop;
        bit  acc;
        fv_t cur;
        fv_t mul_exp;
        int  op;
        int  av;
        int  bv;
        int  cv;
        mul_left = 0;
        hold     = 1'b0;
        cur      = '0;
        mul_exp  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            op = ($urandom_range(3, 0) == 0) ? 10 : int'($urandom_range(15, 0));
            av = int'($urandom_range(255, 0));
            bv = int'($urandom_range(255, 0));
            cv = int'($urandom_range(1, 0));
            drive_op(op, av, bv, cv);
            in_valid  = ($urandom_range(2, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            model_ready = (mul_left == 0) && (!hold || out_ready);
            checks++;
            if (in_ready !== model_ready) begin
                errors++;
                $display("[TB] FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, in_ready, model_ready);
            end
            checks++;
            if (out_valid !== hold) begin
                errors++;
                $display("[TB] FAIL rand_out_valid cyc %0d: got %b expected %b", cyc, out_valid, hold);
            end
            if (hold) begin
                checks++;
                if (obs !== cur) begin
                    errors++;
                    $display("[TB] FAIL rand_result cyc %0d: got %h expected %h", cyc, obs, cur);
                end
            end
            pop = hold && out_ready;
            acc = in_valid && model_ready;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    hold = 1'b1;
                    cur  = mul_exp;
                end
            end else begin
                if (pop) hold = 1'b0;
                if (acc) begin
                    if (op == 10) begin
                        mul_left = 8;
                        mul_exp  = ref_model(op, av, bv, cv);
                    end else begin
                        hold = 1'b1;
                        cur  = ref_model(op, av, bv, cv);
                    end
                end
            end
        end
        @(negedge clk);
        scramble();
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, handshaked successor to the combinational `ALU`, parametrised in width. It accepts one operation per transaction over a valid/ready input channel and returns the result and flags on a registered valid/ready output channel. It keeps the existing opcode set and adds a multi-cycle shift-add multiply (`OP_MUL`). It sits between the instruction-issue logic and the register-file write-back, replacing the combinational ALU where back-pressure is needed.

## Interface
- `B_W`, default 8, operand/result width; minimum 2.
- `clk` input 1: clock; rising edge active.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands and opcode valid.
- `in_ready` output 1: block can accept a transaction this cycle.
- `opcode` input 4: operation select.
- `a`, `b` input `B_W`: operands.
- `c_in` input 1: carry in, used only by `OP_ADD_CARRY`.
- `out_valid` output 1: result registers hold an undelivered result.
- `out_ready` input 1: downstream accepts the result.
- `y` output `B_W`: result.
- `c_out`, `borrow`, `zero`, `parity`, `invalid_op` output 1 each: result flags.

## Operation
- Opcodes: 1 ADD, 2 ADD_CARRY, 3 SUB, 4 INC, 5 DEC, 6 AND, 7 NOT, 8 ROL, 9 ROR, 10 MUL. Values 0 and 11–15 are invalid.
- Arithmetic width rules:
  - ADD, ADD_CARRY and INC produce `{c_out,y}` as a B_W+1 sum.
  - SUB and DEC produce `{borrow,y}` as the B_W+1 two's-complement difference; `borrow` is the MSB.
- Logic and rotate: ROL gives `{a[B_W-2:0],a[B_W-1]}`; ROR gives `{a[0],a[B_W-1:1]}`. AND and NOT are bitwise.
- MUL: `y` is the low B_W bits of the 2·B_W unsigned product a·b. `c_out` is 1 when the high half of the product is nonzero; `borrow` is 0.
- Invalid opcode: `invalid_op`=1 and `y`, `c_out`, `borrow` are all 0.
- Flags not named by an op are 0. `zero` = (y==0). `parity` = ^y.
- FSM states:
  - IDLE: on accept of a non-MUL op, load the result registers and go to HOLD. On accept of MUL, latch a and b, clear the accumulator, and go to MUL.
  - MUL: each cycle, when multiplier bit i is 1, add multiplicand<<i to the 2·B_W accumulator. After the B_W-th iteration, load the result and go to HOLD.
  - HOLD: `out_valid`=1. When `out_ready`=1, go to IDLE, or directly load the next result if a new op is accepted in the same cycle.
- `in_ready` = (state==IDLE) || (state==HOLD && out_ready).
- Inputs are sampled only on the accept edge (`in_valid && in_ready`). Changes to a, b or opcode afterwards have no effect.

## Timing
- Non-MUL latency: accepted at edge N, result and `out_valid` visible after edge N.
- MUL latency: accepted at edge N, `out_valid` rises after edge N+B_W. `in_ready`=0 throughout the MUL state.
- Throughput: one non-MUL op per cycle when `out_ready` is held at 1.
- Back-pressure: in HOLD with `out_ready`=0, `y` and all flags stay stable and `in_ready`=0.
- Simultaneous pop and push in HOLD: the old result is consumed and the new result is loaded on the same edge, so `out_valid` stays 1.
- Reset values: `out_valid`=0, `in_ready`=1 from the first cycle after reset, and `y`, `c_out`, `borrow`, `parity`, `invalid_op` = 0. `zero`=1 because it is derived from `y`=0. The FSM is in IDLE.
- Reset mid-MUL or during HOLD: the operation or result is discarded with no output. Outputs take the reset values after that edge.

## Structure
- `alu_pkg`: opcode localparams (`OP_ADD`…`OP_MUL`), the state encoding (IDLE/MUL/HOLD), and the flag-vector bit positions {invalid_op,parity,zero,borrow,c_out,y}.
- Sub-module `alu_mul_seq`: the shift-add multiplier with start/done, an iteration counter of width clog2(B_W)+1, and the 2·B_W accumulator.
- Top level contains the combinational single-cycle datapath, the FSM and the output register.

## Test plan (B_W=8)
- ADD, a=200, b=100 -> y=44, c_out=1, parity=1, zero=0, `out_valid` one cycle after accept.
- SUB, a=5, b=6 -> y=255, borrow=1, parity=0. DEC, a=0 -> y=255, borrow=1.
- MUL, 15×17 -> y=255, c_out=0, `out_valid` 8 cycles after accept with `in_ready`=0 meanwhile. MUL, 16×16 -> y=0, zero=1, c_out=1.
- Opcode 12, and opcode 0 -> invalid_op=1, y=0, zero=1, parity=0, c_out=0, borrow=0.
- Back-pressure: ADD result with `out_ready`=0 for 5 cycles -> y/flags stable, `in_ready`=0. Then `out_ready`=1 with a queued INC a=255 -> y=0, c_out=1, `out_valid` never drops.
- `rst` asserted 3 cycles into a MUL -> no `out_valid`; the next ADD, 1+1 -> y=2 with normal latency.
